ahb_slave_interface: RTL and testbench
======================================

Name: ahb_slave_interface

Overview:
AHB-facing front end of the AHB-to-APB bridge. It decodes each AHB address phase into a transfer-valid flag and a one-hot APB peripheral select. It also pipelines address, write data and the write flag by up to two cycles. The downstream APB controller FSM consumes these outputs to sequence APB setup and enable phases.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_SLV, 3, number of APB peripherals (width of temp_selx)
BASE_ADDR, 32'h8000_0000, start of the bridge address window
SLV_SIZE, 32'h0400_0000, bytes per peripheral region (64 MiB)

Ports:
hclk  in  1  bus clock, all state on rising edge
hresetn  in  1  reset, synchronous, active-low
hwrite  in  1  AHB write (1) / read (0)
hreadyin  in  1  AHB HREADY from the bus; transfer accepted only when 1
htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data
valid  out  1  combinational: current address phase is an accepted in-window transfer
temp_selx  out  NUM_SLV  combinational one-hot peripheral select
haddr1  out  ADDR_W  haddr delayed 1 cycle
haddr2  out  ADDR_W  haddr delayed 2 cycles
hwdata1  out  DATA_W  hwdata delayed 1 cycle
hwdata2  out  DATA_W  hwdata delayed 2 cycles
hwritereg  out  1  hwrite delayed 1 cycle

Behaviour:
- Reset: on rising hclk edge with hresetn=0, haddr1, haddr2, hwdata1, hwdata2 and hwritereg all clear to 0. Reset takes priority over any input activity, including mid-transfer.
- Pipeline: unconditional every cycle. Latches are not qualified by hreadyin or valid.
  - haddr1<=haddr; haddr2<=haddr1
  - hwdata1<=hwdata; hwdata2<=hwdata1
  - hwritereg<=hwrite
- Window: in_win = (BASE_ADDR <= haddr < BASE_ADDR+NUM_SLV*SLV_SIZE). With defaults this is 0x8000_0000..0x8BFF_FFFF.
- valid = hreadyin AND htrans in {10,11} AND in_win.
  - IDLE and BUSY never assert valid.
  - hreadyin=0 forces valid=0.
- temp_selx: pure address decode, independent of htrans and hreadyin. Bit i=1 iff haddr is in [BASE_ADDR+i*SLV_SIZE, BASE_ADDR+(i+1)*SLV_SIZE).
  - Defaults: 0x8000_0000-0x83FF_FFFF -> 001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100.
  - Outside the window -> all zeros.
  - Region boundaries are inclusive low, exclusive high. 0x8BFF_FFFF selects 100; 0x8C00_0000 gives 000.
- No latency on valid and temp_selx: they are combinational from inputs.
- No internal state beyond the pipeline registers.

Optional Feature:
AHB_SLV_HRESP_EN: adds output hresp (1 bit, registered, reset 0).
- hresp=1 for exactly one cycle following a cycle with hreadyin=1, htrans in {10,11} and in_win=0. Otherwise hresp=0.
- Without the macro, the port and its logic are absent; out-of-window transfers are silently ignored (valid=0).

Decomposition:
- Package ahb_apb_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
  - BASE_ADDR and SLV_SIZE defaults
  - APB controller state encodings (IDLE, WWAIT, WRITE, WRITEP, WENABLE, WENABLEP, READ, RENABLE) shared with the controller
- One sub-module: ahb_addr_decoder, combinational, haddr -> in_win, temp_selx.

Test Plan:
- Reset: hresetn=0 for one edge -> haddr1=haddr2=hwdata1=hwdata2=0, hwritereg=0.
- Write NONSEQ, hreadyin=1, haddr=0x8000_0010, hwdata=0xABCD1234, hwrite=1 -> valid=1, temp_selx=001 immediately. Next edge: haddr1=0x8000_0010, hwdata1=0xABCD1234, hwritereg=1.
- Following cycle haddr=0x8400_0020, hwdata=0x12345678 -> valid=1, temp_selx=010. Next edge: haddr1=0x8400_0020, haddr2=0x8000_0010, hwdata2=0xABCD1234.
- htrans=00, hreadyin=0, haddr=0, hwrite=0 -> valid=0, temp_selx=000. Two edges later the pipeline holds zeros.
- Boundaries with NONSEQ, hreadyin=1:
  - 0x8BFF_FFFF -> valid=1, temp_selx=100
  - 0x8C00_0000 -> valid=0, temp_selx=000
  - 0x7FFF_FFFC -> valid=0
- Qualifiers at 0x8800_0000: htrans=11 with hreadyin=0 -> valid=0, temp_selx=100. htrans=01 with hreadyin=1 -> valid=0. With AHB_SLV_HRESP_EN: NONSEQ to 0x9000_0000 -> hresp=1 next cycle only.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge: HTRANS encodings, address-map defaults
// and the APB controller state encoding.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_SLV_SIZE  = 32'h0400_0000;

    typedef enum logic [2:0] {
        StIdle,
        StWwait,
        StWrite,
        StWriteP,
        StWenable,
        StWenableP,
        StRead,
        StRenable
    } apb_state_e;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational AHB address decoder: window hit and one-hot peripheral select.
module ahb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [ADDR_W-1:0] SLV_SIZE  = ADDR_W'(DEF_SLV_SIZE)
) (
    input  logic [ADDR_W-1:0]  haddr,
    output logic               in_win,
    output logic [NUM_SLV-1:0] temp_selx
);

    // Extra headroom so region upper bounds never wrap past the top of the address space.
    localparam int unsigned EXT_W = ADDR_W + $clog2(NUM_SLV + 1) + 1;

    logic [EXT_W-1:0] addr_ext;
    logic [EXT_W-1:0] region_lo;
    logic [EXT_W-1:0] region_hi;

    always_comb begin
        addr_ext  = EXT_W'(haddr);
        region_lo = '0;
        region_hi = '0;
        temp_selx = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            region_lo    = EXT_W'(BASE_ADDR) + EXT_W'(i) * EXT_W'(SLV_SIZE);
            region_hi    = region_lo + EXT_W'(SLV_SIZE);
            temp_selx[i] = (addr_ext >= region_lo) && (addr_ext < region_hi);
        end
    end

    // Regions are contiguous, so any select bit means the address is inside the window.
    assign in_win = |temp_selx;

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB-facing front end of the AHB-to-APB bridge: transfer qualification, peripheral select
// and a two-deep address/data pipeline. Define AHB_SLV_HRESP_EN to add the hresp output.
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [ADDR_W-1:0] SLV_SIZE  = ADDR_W'(DEF_SLV_SIZE)
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hwrite,
    input  logic               hreadyin,
    input  logic [1:0]         htrans,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [DATA_W-1:0]  hwdata,
    output logic               valid,
    output logic [NUM_SLV-1:0] temp_selx,
    output logic [ADDR_W-1:0]  haddr1,
    output logic [ADDR_W-1:0]  haddr2,
    output logic [DATA_W-1:0]  hwdata1,
    output logic [DATA_W-1:0]  hwdata2,
    output logic               hwritereg
`ifdef AHB_SLV_HRESP_EN
    ,
    output logic               hresp
`endif
);

    logic in_win;
    logic active_trans;

    ahb_addr_decoder #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SLV_SIZE  (SLV_SIZE)
    ) u_addr_decoder (
        .haddr     (haddr),
        .in_win    (in_win),
        .temp_selx (temp_selx)
    );

    assign active_trans = hreadyin &&
                          ((htrans == HtransNonseq) || (htrans == HtransSeq));
    assign valid        = active_trans && in_win;

    // Pipeline runs every cycle; the downstream controller decides which stage to use.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            haddr1    <= '0;
            haddr2    <= '0;
            hwdata1   <= '0;
            hwdata2   <= '0;
            hwritereg <= 1'b0;
        end else begin
            haddr1    <= haddr;
            haddr2    <= haddr1;
            hwdata1   <= hwdata;
            hwdata2   <= hwdata1;
            hwritereg <= hwrite;
        end
    end

`ifdef AHB_SLV_HRESP_EN
    // One-cycle error response to an accepted transfer that misses the window.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            hresp <= 1'b0;
        end else begin
            hresp <= active_trans && !in_win;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Scoreboard bench for ahb_slave_interface: combinational decode checks per vector and
// queued expectations for the registered pipeline outputs.
module tb_ahb_slave_interface;

    logic        hclk;
    logic        hresetn;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        valid;
    logic [2:0]  temp_selx;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata1;
    logic [31:0] hwdata2;
    logic        hwritereg;
`ifdef AHB_SLV_HRESP_EN
    logic        hresp;
`endif

    int checks   = 0;
    int failures = 0;

    ahb_slave_interface dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hwrite    (hwrite),
        .hreadyin  (hreadyin),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .valid     (valid),
        .temp_selx (temp_selx),
        .haddr1    (haddr1),
        .haddr2    (haddr2),
        .hwdata1   (hwdata1),
        .hwdata2   (hwdata2),
        .hwritereg (hwritereg)
`ifdef AHB_SLV_HRESP_EN
        ,
        .hresp     (hresp)
`endif
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  trans;
        logic        rdy;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        exp_valid;
        logic [2:0]  exp_sel;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        htrans   = v.trans;
        hreadyin = v.rdy;
        haddr    = v.addr;
        hwdata   = v.data;
        hwrite   = v.wr;
    endtask

    task automatic pop_and_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("haddr1", haddr1, e.addr);
        check_eq("hwdata1", hwdata1, e.data);
        check_eq("hwritereg", {31'd0, hwritereg}, {31'd0, e.wr});
        check_eq("haddr2", haddr2, prev_addr);
        check_eq("hwdata2", hwdata2, prev_data);
`ifdef AHB_SLV_HRESP_EN
        check_eq("hresp", {31'd0, hresp}, {31'd0, e.err});
`endif
        prev_addr = e.addr;
        prev_data = e.data;
    endtask

    task automatic check_regs_clear(input string tag);
        check_eq({tag, "_haddr1"}, haddr1, 32'd0);
        check_eq({tag, "_haddr2"}, haddr2, 32'd0);
        check_eq({tag, "_hwdata1"}, hwdata1, 32'd0);
        check_eq({tag, "_hwdata2"}, hwdata2, 32'd0);
        check_eq({tag, "_hwritereg"}, {31'd0, hwritereg}, 32'd0);
`ifdef AHB_SLV_HRESP_EN
        check_eq({tag, "_hresp"}, {31'd0, hresp}, 32'd0);
`endif
    endtask

    vec_t vecs[$];

    initial begin
        // trans, rdy, addr, data, wr, exp_valid, exp_sel, exp_err
        vecs.push_back('{2'b10, 1'b1, 32'h8000_0010, 32'hABCD_1234, 1'b1, 1'b1, 3'b001, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 32'h8400_0020, 32'h1234_5678, 1'b0, 1'b1, 3'b010, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 32'h8BFF_FFFF, 32'h1111_2222, 1'b1, 1'b1, 3'b100, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 32'h8C00_0000, 32'h3333_4444, 1'b0, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{2'b10, 1'b1, 32'h7FFF_FFFC, 32'h5555_6666, 1'b1, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{2'b11, 1'b0, 32'h8800_0000, 32'h7777_8888, 1'b0, 1'b0, 3'b100, 1'b0});
        vecs.push_back('{2'b01, 1'b1, 32'h8800_0000, 32'h9999_AAAA, 1'b1, 1'b0, 3'b100, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 32'h9000_0000, 32'hBBBB_CCCC, 1'b1, 1'b0, 3'b000, 1'b1});
        vecs.push_back('{2'b00, 1'b1, 32'h8000_0000, 32'hDDDD_EEEE, 1'b0, 1'b0, 3'b001, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 32'h83FF_FFFF, 32'h0F0F_0F0F, 1'b1, 1'b1, 3'b001, 1'b0});
        vecs.push_back('{2'b10, 1'b1, 32'h8400_0000, 32'hF0F0_F0F0, 1'b0, 1'b1, 3'b010, 1'b0});
        vecs.push_back('{2'b11, 1'b1, 32'h87FF_FFFF, 32'h2468_ACE0, 1'b1, 1'b1, 3'b010, 1'b0});
        vecs.push_back('{2'b00, 1'b1, 32'h8C00_0000, 32'h1357_9BDF, 1'b0, 1'b0, 3'b000, 1'b0});
    end

    initial begin
        // Reset asserted with an active transfer on the bus: reset must win.
        hresetn  = 1'b0;
        htrans   = 2'b10;
        hreadyin = 1'b1;
        haddr    = 32'h8000_0004;
        hwdata   = 32'hDEAD_BEEF;
        hwrite   = 1'b1;
        @(posedge hclk);
        #1;
        check_regs_clear("reset");
        hresetn   = 1'b1;
        prev_addr = 32'd0;
        prev_data = 32'd0;

        foreach (vecs[k]) begin
            drive(vecs[k]);
            exp_q.push_back('{vecs[k].addr, vecs[k].data, vecs[k].wr, vecs[k].exp_err});
            #3;
            check_eq($sformatf("valid[%0d]", k), {31'd0, valid}, {31'd0, vecs[k].exp_valid});
            check_eq($sformatf("temp_selx[%0d]", k), {29'd0, temp_selx},
                     {29'd0, vecs[k].exp_sel});
            @(posedge hclk);
            #1;
            pop_and_check();
        end

        // Reset in the middle of an out-of-window transfer clears everything, hresp included.
        drive('{2'b10, 1'b1, 32'h9000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 3'b000, 1'b1});
        hresetn = 1'b0;
        @(posedge hclk);
        #1;
        check_regs_clear("mid_reset");
        exp_q.delete();
        hresetn   = 1'b1;
        prev_addr = 32'd0;
        prev_data = 32'd0;

        drive('{2'b10, 1'b1, 32'h8800_0040, 32'h0BAD_CAFE, 1'b1, 1'b1, 3'b100, 1'b0});
        exp_q.push_back('{32'h8800_0040, 32'h0BAD_CAFE, 1'b1, 1'b0});
        #3;
        check_eq("valid_post_reset", {31'd0, valid}, 32'd1);
        check_eq("temp_selx_post_reset", {29'd0, temp_selx}, 32'd4);
        @(posedge hclk);
        #1;
        pop_and_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
